frame_writer: RTL and testbench

//  Write side of the frame RAM that the VGA painter reads. Accepts a raster-order

---
 rtl/frame_wr_pkg.sv | 28 ++
 rtl/frame_writer_if.sv | 35 +++
 rtl/frame_writer_raster_counter.sv | 62 ++++++
 rtl/frame_writer.sv | 143 ++++++++++++++
 tb/tb_frame_writer.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_wr_pkg.sv
// -----------------------------------------------------------------------------
// frame_wr_pkg
// Shared definitions for the frame RAM write side. The painter reads the same
// frame geometry constants, so they live here rather than in the writer.
//   FRAME_IMG_W / FRAME_IMG_H  default frame geometry (pixels / lines)
//   FRAME_DATA_W               pixel width (RGB332 byte)
//   FRAME_ADDR_W               frame RAM address width
//   frame_wr_state_e           writer FSM state encoding
//   cnt_width()                counter width for a 0..n-1 range (min 1 bit)
// -----------------------------------------------------------------------------
package frame_wr_pkg;

    localparam int FRAME_IMG_W  = 64;
    localparam int FRAME_IMG_H  = 64;
    localparam int FRAME_DATA_W = 8;
    localparam int FRAME_ADDR_W = 19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } frame_wr_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_writer_if.sv
// -----------------------------------------------------------------------------
// frame_writer_if
// Bundles the pixel stream from the filter datapath and the frame RAM write
// port of the frame writer.
//   in_data/in_valid/in_eol  pixel stream towards the writer
//   in_ready                 writer accepts a pixel this cycle
//   we/waddr/wdata           frame RAM write strobe, address and data
// Modports: master = pixel source / RAM observer, slave = frame writer.
// -----------------------------------------------------------------------------
interface frame_writer_if
    import frame_wr_pkg::*;
#(
    parameter int DATA_W = FRAME_DATA_W,
    parameter int ADDR_W = FRAME_ADDR_W
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_eol;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport master (
        output in_data, in_valid, in_eol,
        input  in_ready, we, waddr, wdata
    );

    modport slave (
        input  in_data, in_valid, in_eol,
        output in_ready, we, waddr, wdata
    );

endinterface

// File: rtl/frame_writer_raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Raster position of the next pixel to be written (x along the line, y line).
//   clk, rst     clock, asynchronous active-high reset
//   clr          return to (0,0); wins over en
//   en           advance one pixel in raster order
//   last_x       current pixel is the last of its line
//   last_pixel   current pixel is the last of the frame
// -----------------------------------------------------------------------------
module raster_counter
    import frame_wr_pkg::*;
#(
    parameter int IMG_W = FRAME_IMG_W,
    parameter int IMG_H = FRAME_IMG_H
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last_x,
    output logic last_pixel
);

    localparam int X_W = cnt_width(IMG_W);
    localparam int Y_W = cnt_width(IMG_H);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           last_y;

    assign last_x     = (x_q == X_W'(IMG_W - 1));
    assign last_y     = (y_q == Y_W'(IMG_H - 1));
    assign last_pixel = last_x && last_y;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            if (last_x) begin
                x_d = '0;
                // explicit wrap keeps non-power-of-two heights in range
                y_d = last_y ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/frame_writer.sv
// -----------------------------------------------------------------------------
// frame_writer
// Write side of the frame RAM read by the VGA painter. Takes a raster-order
// pixel stream over valid/ready and writes one IMG_W x IMG_H frame to linear
// addresses starting at BASE_ADDR, then pulses done.
//   clk, rst   clock, asynchronous active-high reset
//   start      1-cycle pulse, begins a frame (ignored unless idle)
//   pix        frame_writer_if.slave: pixel stream in, RAM write port out
//   busy       frame in progress (WRITE and the final DONE cycle)
//   done       1-cycle pulse coincident with the last RAM write
//   err        sticky line-length error
// Optional feature macro: FRAME_WR_EOL_CHECK_EN enables the in_eol check;
// without it in_eol is ignored and err is held at 0.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; stream not accepted
//   ST_WRITE | accepting pixels, one per cycle when in_valid
//   ST_DONE  | final write on the RAM port; done pulse; back to idle
// -----------------------------------------------------------------------------
module frame_writer
    import frame_wr_pkg::*;
#(
    parameter int          IMG_W     = FRAME_IMG_W,
    parameter int          IMG_H     = FRAME_IMG_H,
    parameter int          DATA_W    = FRAME_DATA_W,
    parameter int          ADDR_W    = FRAME_ADDR_W,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    frame_writer_if.slave  pix,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam longint unsigned LAST_ADDR = 64'(BASE_ADDR) + 64'(IMG_W) * 64'(IMG_H) - 64'd1;
    localparam longint unsigned RAM_WORDS = 64'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    if (LAST_ADDR >= RAM_WORDS) begin : g_geom_check
        $error("frame_writer: frame does not fit in the RAM address space");
    end

    frame_wr_state_e   state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              start_acc;
    logic              accept;
    logic              last_x;
    logic              last_pixel;

    assign start_acc = start && (state_q == ST_IDLE);
    assign accept    = pix.in_valid && (state_q == ST_WRITE);

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_acc),
        .en         (accept),
        .last_x     (last_x),
        .last_pixel (last_pixel)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_acc) state_d = ST_WRITE;
            ST_WRITE: if (accept && last_pixel) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // addr_q is the address of the next pixel; the write port is one cycle
    // behind so the final write lands in the DONE cycle.
    always_comb begin
        we_d    = accept;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        if (start_acc) begin
            addr_d = BASE;
        end else if (accept) begin
            waddr_d = addr_q;
            wdata_d = pix.in_data;
            addr_d  = addr_q + ADDR_W'(1);
        end
    end

`ifdef FRAME_WR_EOL_CHECK_EN
    // counters are not resynced on a mismatch; the frame keeps its raster order
    always_comb begin
        err_d = err_q;
        if (start_acc) begin
            err_d = 1'b0;
        end else if (accept && (pix.in_eol != last_x)) begin
            err_d = 1'b1;
        end
    end
`else
    logic unused_eol;
    logic unused_last_x;
    assign unused_eol    = pix.in_eol;
    assign unused_last_x = last_x;
    assign err_d         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            waddr_q <= BASE;
            wdata_q <= '0;
            addr_q  <= BASE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign pix.in_ready = (state_q == ST_WRITE);
    assign pix.we       = we_q;
    assign pix.waddr    = waddr_q;
    assign pix.wdata    = wdata_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign err          = err_q;

endmodule

// File: tb/tb_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_frame_writer
// Self-checking bench for frame_writer. Two instances share one stimulus
// stream: dut0 with BASE_ADDR = 0 and dut1 with BASE_ADDR = 0x28. Expected
// RAM writes are queued as pixels are driven and popped by a negedge monitor.
// Honours FRAME_WR_EOL_CHECK_EN for the err expectations.
// -----------------------------------------------------------------------------
module tb_frame_writer;

    localparam int          NPIX  = 4096;
    localparam logic [18:0] BASE0 = 19'h0;
    localparam logic [18:0] BASE1 = 19'h28;

    typedef struct packed {
        logic [18:0] a;
        logic [7:0]  d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] drv_data;
    logic       drv_valid;
    logic       drv_eol;
    logic       busy0, done0, err0;
    logic       busy1, done1, err1;

    int   vec_cnt = 0;
    int   miscmp  = 0;
    int   we_cnt0 = 0;
    int   done_cnt0 = 0;
    int   ready_low = 0;
    bit   writing = 1'b0;
    bit   first_seen1 = 1'b0;
    logic [18:0] first_addr1, last_addr1;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    frame_writer_if #(.DATA_W(8), .ADDR_W(19)) if0 ();
    frame_writer_if #(.DATA_W(8), .ADDR_W(19)) if1 ();

    assign if0.in_data  = drv_data;
    assign if0.in_valid = drv_valid;
    assign if0.in_eol   = drv_eol;
    assign if1.in_data  = drv_data;
    assign if1.in_valid = drv_valid;
    assign if1.in_eol   = drv_eol;

    frame_writer #(.BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .pix(if0),
        .busy(busy0), .done(done0), .err(err0)
    );

    frame_writer #(.BASE_ADDR(32'h28)) dut1 (
        .clk(clk), .rst(rst), .start(start), .pix(if1),
        .busy(busy1), .done(done1), .err(err1)
    );

    // scoreboard monitor
    always @(negedge clk) begin
        if (if0.we === 1'b1) begin
            vec_cnt++;
            we_cnt0++;
            if (q0.size() == 0) begin
                miscmp++;
                $display("FAIL we0_unexpected: got write addr=%h data=%h, required no write", if0.waddr, if0.wdata);
            end else begin
                e0 = q0.pop_front();
                if (if0.waddr !== e0.a || if0.wdata !== e0.d) begin
                    miscmp++;
                    $display("FAIL wr0: got addr=%h data=%h, required addr=%h data=%h", if0.waddr, if0.wdata, e0.a, e0.d);
                end
            end
        end
        if (if1.we === 1'b1) begin
            vec_cnt++;
            if (!first_seen1) begin
                first_seen1 = 1'b1;
                first_addr1 = if1.waddr;
            end
            last_addr1 = if1.waddr;
            if (q1.size() == 0) begin
                miscmp++;
                $display("FAIL we1_unexpected: got write addr=%h, required no write", if1.waddr);
            end else begin
                e1 = q1.pop_front();
                if (if1.waddr !== e1.a || if1.wdata !== e1.d) begin
                    miscmp++;
                    $display("FAIL wr1: got addr=%h data=%h, required addr=%h data=%h", if1.waddr, if1.wdata, e1.a, e1.d);
                end
            end
        end
        if (done0 === 1'b1) begin
            vec_cnt++;
            done_cnt0++;
            if (if0.we !== 1'b1 || q0.size() != 0) begin
                miscmp++;
                $display("FAIL done0_align: got we=%b pending=%0d, required we=1 pending=0", if0.we, q0.size());
            end
        end
        if (done1 === 1'b1) begin
            vec_cnt++;
            if (if1.we !== 1'b1 || q1.size() != 0) begin
                miscmp++;
                $display("FAIL done1_align: got we=%b pending=%0d, required we=1 pending=0", if1.we, q1.size());
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        writing = 1'b1;
    endtask

    // drives n pixels in raster order; queues expectations while the model is writing
    task automatic drive_frame(input int n, input int gap_pct, input int start_at, input int bad_eol_at);
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                drv_valid = 1'b0;
                drv_eol   = 1'b0;
                if (if0.in_ready !== 1'b1) ready_low++;
                @(posedge clk); #1;
            end
            if (if0.in_ready !== 1'b1) ready_low++;
            drv_valid = 1'b1;
            drv_data  = i[7:0];
            drv_eol   = ((i % 64) == 63) || (i == bad_eol_at);
            start     = (i == start_at);
            if (writing) begin
                q0.push_back('{a: BASE0 + 19'(i), d: i[7:0]});
                q1.push_back('{a: BASE1 + 19'(i), d: i[7:0]});
                if (i == NPIX - 1) writing = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        drv_valid = 1'b0;
        drv_eol   = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vec_cnt++;
        if (if0.we !== 1'b0 || if0.waddr !== BASE0 || if0.wdata !== 8'h00 || if0.in_ready !== 1'b0) begin
            miscmp++;
            $display("FAIL reset_port0: got we=%b waddr=%h wdata=%h rdy=%b, required 0/%h/00/0", if0.we, if0.waddr, if0.wdata, if0.in_ready, BASE0);
        end
        vec_cnt++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0) begin
            miscmp++;
            $display("FAIL reset_status0: got busy=%b done=%b err=%b, required 0/0/0", busy0, done0, err0);
        end
        vec_cnt++;
        if (if1.waddr !== BASE1) begin
            miscmp++;
            $display("FAIL reset_waddr1: got %h, required %h", if1.waddr, BASE1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        we_cnt0 = 0;
        done_cnt0 = 0;
        do_start();
        vec_cnt++;
        if (busy0 !== 1'b1 || if0.in_ready !== 1'b1) begin
            miscmp++;
            $display("FAIL start_busy: got busy=%b rdy=%b, required 1/1", busy0, if0.in_ready);
        end
        drive_frame(NPIX, 0, -1, -1);
        vec_cnt++;
        if (done0 !== 1'b1 || if0.we !== 1'b1 || busy0 !== 1'b1 || if0.waddr !== 19'd4095) begin
            miscmp++;
            $display("FAIL last_write: got done=%b we=%b busy=%b waddr=%h, required 1/1/1/00fff", done0, if0.we, busy0, if0.waddr);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if (done0 !== 1'b0 || busy0 !== 1'b0 || if0.in_ready !== 1'b0 || if0.we !== 1'b0) begin
            miscmp++;
            $display("FAIL after_done: got done=%b busy=%b rdy=%b we=%b, required 0/0/0/0", done0, busy0, if0.in_ready, if0.we);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if (we_cnt0 !== NPIX || done_cnt0 !== 1 || err0 !== 1'b0) begin
            miscmp++;
            $display("FAIL frame_counts: got we=%0d done=%0d err=%b, required %0d/1/0", we_cnt0, done_cnt0, err0, NPIX);
        end
    endtask

    task automatic test_base_addr();
        first_seen1 = 1'b0;
        do_start();
        drive_frame(NPIX, 0, -1, -1);
        repeat (2) begin @(posedge clk); #1; end
        vec_cnt++;
        if (first_addr1 !== 19'h00028 || last_addr1 !== 19'h01027) begin
            miscmp++;
            $display("FAIL base_addr: got first=%h last=%h, required 00028/01027", first_addr1, last_addr1);
        end
    endtask

    task automatic test_gaps();
        we_cnt0 = 0;
        ready_low = 0;
        do_start();
        drive_frame(NPIX, 50, -1, -1);
        repeat (2) begin @(posedge clk); #1; end
        vec_cnt++;
        if (ready_low !== 0 || we_cnt0 !== NPIX) begin
            miscmp++;
            $display("FAIL gaps: got ready_low=%0d we=%0d, required 0/%0d", ready_low, we_cnt0, NPIX);
        end
    endtask

    task automatic test_ignore();
        we_cnt0 = 0;
        do_start();
        drive_frame(NPIX, 0, 100, -1);
        // now in the DONE cycle: start and valid must both be ignored
        drv_valid = 1'b1;
        drv_data  = 8'hAA;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vec_cnt++;
        if (if0.in_ready !== 1'b0 || busy0 !== 1'b0) begin
            miscmp++;
            $display("FAIL start_in_done: got rdy=%b busy=%b, required 0/0", if0.in_ready, busy0);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            vec_cnt++;
            if (if0.we !== 1'b0) begin
                miscmp++;
                $display("FAIL idle_valid_we: got we=%b, required 0", if0.we);
            end
        end
        drv_valid = 1'b0;
        vec_cnt++;
        if (we_cnt0 !== NPIX) begin
            miscmp++;
            $display("FAIL ignore_count: got we=%0d, required %0d", we_cnt0, NPIX);
        end
    endtask

    task automatic test_mid_reset();
        do_start();
        drive_frame(2000, 0, -1, -1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        vec_cnt++;
        if (if0.we !== 1'b0 || if0.waddr !== BASE0 || if0.wdata !== 8'h00 || if0.in_ready !== 1'b0) begin
            miscmp++;
            $display("FAIL mid_rst_port: got we=%b waddr=%h wdata=%h rdy=%b, required 0/%h/00/0", if0.we, if0.waddr, if0.wdata, if0.in_ready, BASE0);
        end
        vec_cnt++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || if1.waddr !== BASE1 || q0.size() != 0) begin
            miscmp++;
            $display("FAIL mid_rst_status: got busy=%b done=%b waddr1=%h pending=%0d, required 0/0/%h/0", busy0, done0, if1.waddr, q0.size(), BASE1);
        end
        writing = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        we_cnt0 = 0;
        do_start();
        drive_frame(NPIX, 0, -1, -1);
        repeat (2) begin @(posedge clk); #1; end
        vec_cnt++;
        if (we_cnt0 !== NPIX) begin
            miscmp++;
            $display("FAIL rewrite_count: got we=%0d, required %0d", we_cnt0, NPIX);
        end
    endtask

    task automatic test_eol();
        logic exp_err;
`ifdef FRAME_WR_EOL_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_start();
        drive_frame(NPIX, 0, -1, 3 * 64 + 62);
        vec_cnt++;
        if (err0 !== exp_err || err1 !== exp_err || done0 !== 1'b1) begin
            miscmp++;
            $display("FAIL eol_err_at_done: got err0=%b err1=%b done=%b, required %b/%b/1", err0, err1, done0, exp_err, exp_err);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if (err0 !== exp_err) begin
            miscmp++;
            $display("FAIL eol_err_sticky: got %b, required %b", err0, exp_err);
        end
        do_start();
        vec_cnt++;
        if (err0 !== 1'b0) begin
            miscmp++;
            $display("FAIL eol_err_clear: got %b, required 0", err0);
        end
        drive_frame(NPIX, 0, -1, -1);
        repeat (2) begin @(posedge clk); #1; end
        vec_cnt++;
        if (err0 !== 1'b0) begin
            miscmp++;
            $display("FAIL eol_clean_frame: got %b, required 0", err0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        drv_data  = 8'h00;
        drv_valid = 1'b0;
        drv_eol   = 1'b0;
        test_reset();
        test_full_frame();
        test_base_addr();
        test_gaps();
        test_ignore();
        test_mid_reset();
        test_eol();
        repeat (2) begin @(posedge clk); #1; end
        vec_cnt++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscmp++;
            $display("FAIL pending_writes: got %0d/%0d outstanding, required 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
